// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing definitions for the sync generator and its axis sub-module.
//   - Bus widths of the timing configuration inputs and the pixel counters.
//   - 640x480 @ 60 Hz default timing, used as the reset value of the shadow registers.
//   - Controller state encoding.
package vga_sync_gen_pkg;

  // Configuration bus widths
  localparam int unsigned PulseWidth    = 8;
  localparam int unsigned RezMaxWidth   = 11;
  localparam int unsigned HlMarginWidth = 8;
  localparam int unsigned HrMarginWidth = 6;
  localparam int unsigned VlMarginWidth = 6;
  localparam int unsigned VrMarginWidth = 4;

  // 640x480 default timing: count-max values are total-1
  localparam int unsigned DefHSyncPulse   = 96;
  localparam int unsigned DefHCountMax    = 799;
  localparam int unsigned DefHLeftMargin  = 48;
  localparam int unsigned DefHRightMargin = 16;
  localparam int unsigned DefVSyncPulse   = 2;
  localparam int unsigned DefVCountMax    = 524;
  localparam int unsigned DefVLeftMargin  = 33;
  localparam int unsigned DefVRightMargin = 10;

  // Controller states
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPrep = 2'b01,
    StRun  = 2'b10
  } vga_state_e;

endpackage

// File: rtl/vga_sync_gen_timing_axis.sv
// vga_timing_axis: one axis (horizontal or vertical) of the VGA timing generator.
// A counter with enable and clear that wraps at max_i, plus combinational decode of
// the sync, active-area and start conditions against the registered bounds.
// Ports:
//   clk_i, rst_ni    pixel clock, asynchronous active-low reset
//   en_i             advance the counter this cycle
//   clr_i            force the counter to 0 (wins over en_i)
//   max_i            last count value before wrapping to 0
//   pulse_i          sync length; sync_o is set while cnt < pulse_i
//   act_start_i      first active count (one bit wider than the counter)
//   act_last_i       last active count (one bit wider than the counter)
//   cnt_o            current count
//   wrap_o           counter wraps on this edge (enabled, not cleared, at max)
//   sync_o           raw sync condition, active high
//   active_o         count lies in [act_start_i, act_last_i]
//   start_o          count is 0
module vga_timing_axis #(
  parameter int unsigned CntWidth   = 11,
  parameter int unsigned PulseWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic [CntWidth-1:0] max_i,
  input  logic [PulseWidth-1:0] pulse_i,
  input  logic [CntWidth:0]   act_start_i,
  input  logic [CntWidth:0]   act_last_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                wrap_o,
  output logic                sync_o,
  output logic                active_o,
  output logic                start_o
);

  // Compare width large enough for both the counter and the pulse length
  localparam int unsigned CmpWidth = (PulseWidth > CntWidth) ? PulseWidth : CntWidth;

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                at_max;

  assign at_max = (cnt_q == max_i);
  assign wrap_o = en_i & ~clr_i & at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign sync_o   = (CmpWidth'(cnt_q) < CmpWidth'(pulse_i));
  assign active_o = ({1'b0, cnt_q} >= act_start_i) && ({1'b0, cnt_q} <= act_last_i);
  assign start_o  = (cnt_q == '0);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator.
// Captures a timing configuration into shadow registers on Load_config, derives the
// active-area bounds, then runs horizontal/vertical counters and produces registered
// sync, display-enable, pixel coordinate and line/frame start outputs.
// Ports:
//   clk, rst_n                       pixel clock, asynchronous active-low reset
//   Load_config                      timing inputs are valid; capture and restart
//   H_/V_sync_pulse                  sync length in clocks / lines
//   H_/V_count_max                   total clocks per line - 1 / lines per frame - 1
//   H_/V_left_margin                 back porch
//   H_/V_right_margin                front porch
//   H_sync, V_sync                   sync outputs, polarity from SYNC_ACTIVE_LOW
//   Display_en                       inside the active area
//   Pixel_x, Pixel_y                 active-area coordinates, 0 outside it
//   Line_start, Frame_start          outputs describe h=0 / (0,0)
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH     = PulseWidth,
  parameter int unsigned REZ_MAX_WIDTH   = RezMaxWidth,
  parameter int unsigned HL_MARGIN_WIDTH = HlMarginWidth,
  parameter int unsigned HR_MARGIN_WIDTH = HrMarginWidth,
  parameter int unsigned VL_MARGIN_WIDTH = VlMarginWidth,
  parameter int unsigned VR_MARGIN_WIDTH = VrMarginWidth,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Load_config,
  input  logic [PULSE_WIDTH-1:0]     H_sync_pulse,
  input  logic [PULSE_WIDTH-1:0]     V_sync_pulse,
  input  logic [REZ_MAX_WIDTH-1:0]   H_count_max,
  input  logic [REZ_MAX_WIDTH-1:0]   V_count_max,
  input  logic [HL_MARGIN_WIDTH-1:0] H_left_margin,
  input  logic [VL_MARGIN_WIDTH-1:0] V_left_margin,
  input  logic [HR_MARGIN_WIDTH-1:0] H_right_margin,
  input  logic [VR_MARGIN_WIDTH-1:0] V_right_margin,
  output logic                       H_sync,
  output logic                       V_sync,
  output logic                       Display_en,
  output logic [REZ_MAX_WIDTH-1:0]   Pixel_x,
  output logic [REZ_MAX_WIDTH-1:0]   Pixel_y,
  output logic                       Line_start,
  output logic                       Frame_start
);

  localparam int unsigned BndWidth = REZ_MAX_WIDTH + 1;
  // Idle sync level equals the polarity flag: active-low syncs idle high
  localparam logic SyncIdle = SYNC_ACTIVE_LOW;

  // ---------------------------------------------------------------------------
  // Shadow configuration registers
  // ---------------------------------------------------------------------------
  logic [PULSE_WIDTH-1:0]     h_pulse_q, h_pulse_d, v_pulse_q, v_pulse_d;
  logic [REZ_MAX_WIDTH-1:0]   h_max_q, h_max_d, v_max_q, v_max_d;
  logic [HL_MARGIN_WIDTH-1:0] h_lmar_q, h_lmar_d;
  logic [HR_MARGIN_WIDTH-1:0] h_rmar_q, h_rmar_d;
  logic [VL_MARGIN_WIDTH-1:0] v_lmar_q, v_lmar_d;
  logic [VR_MARGIN_WIDTH-1:0] v_rmar_q, v_rmar_d;

  always_comb begin
    h_pulse_d = h_pulse_q;
    v_pulse_d = v_pulse_q;
    h_max_d   = h_max_q;
    v_max_d   = v_max_q;
    h_lmar_d  = h_lmar_q;
    h_rmar_d  = h_rmar_q;
    v_lmar_d  = v_lmar_q;
    v_rmar_d  = v_rmar_q;
    if (Load_config) begin
      h_pulse_d = H_sync_pulse;
      v_pulse_d = V_sync_pulse;
      h_max_d   = H_count_max;
      v_max_d   = V_count_max;
      h_lmar_d  = H_left_margin;
      h_rmar_d  = H_right_margin;
      v_lmar_d  = V_left_margin;
      v_rmar_d  = V_right_margin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pulse_q <= PULSE_WIDTH'(DefHSyncPulse);
      v_pulse_q <= PULSE_WIDTH'(DefVSyncPulse);
      h_max_q   <= REZ_MAX_WIDTH'(DefHCountMax);
      v_max_q   <= REZ_MAX_WIDTH'(DefVCountMax);
      h_lmar_q  <= HL_MARGIN_WIDTH'(DefHLeftMargin);
      h_rmar_q  <= HR_MARGIN_WIDTH'(DefHRightMargin);
      v_lmar_q  <= VL_MARGIN_WIDTH'(DefVLeftMargin);
      v_rmar_q  <= VR_MARGIN_WIDTH'(DefVRightMargin);
    end else begin
      h_pulse_q <= h_pulse_d;
      v_pulse_q <= v_pulse_d;
      h_max_q   <= h_max_d;
      v_max_q   <= v_max_d;
      h_lmar_q  <= h_lmar_d;
      h_rmar_q  <= h_rmar_d;
      v_lmar_q  <= v_lmar_d;
      v_rmar_q  <= v_rmar_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Active-area bounds, one bit wider than the counters so that the sum cannot
  // overflow and a front porch larger than count-max shows up as underflow.
  // Registered every cycle; the shadows only move on a load, and the outputs are
  // held at reset values until the bounds have settled.
  // ---------------------------------------------------------------------------
  logic [BndWidth-1:0] h_start_q, h_start_d, h_last_q, h_last_d;
  logic [BndWidth-1:0] v_start_q, v_start_d, v_last_q, v_last_d;
  logic                degen_q, degen_d;
  logic                h_uflow, v_uflow;

  always_comb begin
    h_start_d = BndWidth'(h_pulse_q) + BndWidth'(h_lmar_q);
    v_start_d = BndWidth'(v_pulse_q) + BndWidth'(v_lmar_q);
    h_last_d  = BndWidth'(h_max_q) - BndWidth'(h_rmar_q);
    v_last_d  = BndWidth'(v_max_q) - BndWidth'(v_rmar_q);
    h_uflow   = BndWidth'(h_rmar_q) > BndWidth'(h_max_q);
    v_uflow   = BndWidth'(v_rmar_q) > BndWidth'(v_max_q);
    degen_d   = h_uflow | v_uflow | (h_start_d > h_last_d) | (v_start_d > v_last_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_start_q <= BndWidth'(DefHSyncPulse + DefHLeftMargin);
      h_last_q  <= BndWidth'(DefHCountMax - DefHRightMargin);
      v_start_q <= BndWidth'(DefVSyncPulse + DefVLeftMargin);
      v_last_q  <= BndWidth'(DefVCountMax - DefVRightMargin);
      degen_q   <= 1'b0;
    end else begin
      h_start_q <= h_start_d;
      h_last_q  <= h_last_d;
      v_start_q <= v_start_d;
      v_last_q  <= v_last_d;
      degen_q   <= degen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. load_q delays the load by one edge so the bounds are registered
  // from the new shadows before PREP releases into RUN.
  // ---------------------------------------------------------------------------
  vga_state_e state_q, state_d;
  logic       load_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_q) state_d = StPrep;
      StPrep:  state_d = load_q ? StPrep : StRun;
      StRun:   if (load_q) state_d = StPrep;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= Load_config;
    end
  end

  // A load aborts the frame at once: counters clear and the outputs drop to reset
  // values on the load edge itself, so a coincident wrap never becomes visible.
  logic run_ok, cnt_clr, cnt_en;

  assign cnt_en  = (state_q == StRun);
  assign cnt_clr = (state_q != StRun) | load_q | Load_config;
  assign run_ok  = (state_q == StRun) & ~load_q & ~Load_config;

  // ---------------------------------------------------------------------------
  // Axis counters
  // ---------------------------------------------------------------------------
  logic [REZ_MAX_WIDTH-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  logic h_sync_raw, v_sync_raw, h_act, v_act, h_start, v_start;

  vga_timing_axis #(
    .CntWidth   (REZ_MAX_WIDTH),
    .PulseWidth (PULSE_WIDTH)
  ) u_h_axis (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (cnt_en),
    .clr_i       (cnt_clr),
    .max_i       (h_max_q),
    .pulse_i     (h_pulse_q),
    .act_start_i (h_start_q),
    .act_last_i  (h_last_q),
    .cnt_o       (h_cnt),
    .wrap_o      (h_wrap),
    .sync_o      (h_sync_raw),
    .active_o    (h_act),
    .start_o     (h_start)
  );

  vga_timing_axis #(
    .CntWidth   (REZ_MAX_WIDTH),
    .PulseWidth (PULSE_WIDTH)
  ) u_v_axis (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (h_wrap),
    .clr_i       (cnt_clr),
    .max_i       (v_max_q),
    .pulse_i     (v_pulse_q),
    .act_start_i (v_start_q),
    .act_last_i  (v_last_q),
    .cnt_o       (v_cnt),
    .wrap_o      (v_wrap),
    .sync_o      (v_sync_raw),
    .active_o    (v_act),
    .start_o     (v_start)
  );

  // Frame wrap is implied by the counters themselves; nothing downstream needs it.
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

  // ---------------------------------------------------------------------------
  // Registered outputs: each cycle describes the counter value of the previous one
  // ---------------------------------------------------------------------------
  logic                     h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic                     disp_q, disp_d, line_q, line_d, frame_q, frame_d;
  logic [REZ_MAX_WIDTH-1:0] px_q, px_d, py_q, py_d;

  always_comb begin
    h_sync_d = SyncIdle;
    v_sync_d = SyncIdle;
    disp_d   = 1'b0;
    px_d     = '0;
    py_d     = '0;
    line_d   = 1'b0;
    frame_d  = 1'b0;
    if (run_ok) begin
      h_sync_d = h_sync_raw ? ~SyncIdle : SyncIdle;
      v_sync_d = v_sync_raw ? ~SyncIdle : SyncIdle;
      disp_d   = h_act & v_act & ~degen_q;
      line_d   = h_start;
      frame_d  = h_start & v_start;
      if (disp_d) begin
        px_d = h_cnt - h_start_q[REZ_MAX_WIDTH-1:0];
        py_d = v_cnt - v_start_q[REZ_MAX_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_sync_q <= SyncIdle;
      v_sync_q <= SyncIdle;
      disp_q   <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      disp_q   <= disp_d;
      px_q     <= px_d;
      py_q     <= py_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign H_sync      = h_sync_q;
  assign V_sync      = v_sync_q;
  assign Display_en  = disp_q;
  assign Pixel_x     = px_q;
  assign Pixel_y     = py_q;
  assign Line_start  = line_q;
  assign Frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. The reference model tracks k, the position within the
// running frame sequence that the outputs should describe; all expected outputs
// are derived from k and the configuration captured on the last load edge.
module tb_vga_sync_gen;

  typedef struct {
    int hmax; int hp; int hl; int hr;
    int vmax; int vp; int vl; int vr;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  h_pulse, v_pulse;
  logic [10:0] h_max, v_max;
  logic [7:0]  h_lm;
  logic [5:0]  h_rm;
  logic [5:0]  v_lm;
  logic [3:0]  v_rm;
  logic        h_sync, v_sync, disp, line_s, frame_s;
  logic [10:0] px, py;

  int     total = 0;
  int     bad = 0;
  bit     loaded = 1'b0;
  longint k = 0;
  cfg_t   cur, cap;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Load_config    (load),
    .H_sync_pulse   (h_pulse),
    .V_sync_pulse   (v_pulse),
    .H_count_max    (h_max),
    .V_count_max    (v_max),
    .H_left_margin  (h_lm),
    .V_left_margin  (v_lm),
    .H_right_margin (h_rm),
    .V_right_margin (v_rm),
    .H_sync         (h_sync),
    .V_sync         (v_sync),
    .Display_en     (disp),
    .Pixel_x        (px),
    .Pixel_y        (py),
    .Line_start     (line_s),
    .Frame_start    (frame_s)
  );

  function automatic logic [26:0] reset_vec();
    return {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
  endfunction

  function automatic logic [26:0] obs_vec();
    return {h_sync, v_sync, disp, px, py, line_s, frame_s};
  endfunction

  function automatic logic [26:0] model_vec();
    int h, v, hst, hla, vst, vla;
    logic hs, vs, de;
    logic [10:0] mx, my;
    if (!loaded || k < 0) return reset_vec();
    h   = int'(k % longint'(cap.hmax + 1));
    v   = int'((k / longint'(cap.hmax + 1)) % longint'(cap.vmax + 1));
    hst = cap.hp + cap.hl;
    hla = cap.hmax - cap.hr;
    vst = cap.vp + cap.vl;
    vla = cap.vmax - cap.vr;
    hs  = (h < cap.hp);
    vs  = (v < cap.vp);
    de  = !(hla < 0 || hst > hla || vla < 0 || vst > vla) &&
          h >= hst && h <= hla && v >= vst && v <= vla;
    mx  = de ? 11'(h - hst) : 11'd0;
    my  = de ? 11'(v - vst) : 11'd0;
    return {~hs, ~vs, de, mx, my, logic'(h == 0), logic'(h == 0 && v == 0)};
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [26:0] exp);
    logic [26:0] o;
    o = obs_vec();
    total++;
    assert (o === exp) else begin
      bad++;
      $error("FAIL %s k=%0d: observed %h expected %h", tag, k, o, exp);
    end
  endtask

  task automatic drive(input cfg_t c);
    cur     = c;
    h_max   = 11'(c.hmax);
    h_pulse = 8'(c.hp);
    h_lm    = 8'(c.hl);
    h_rm    = 6'(c.hr);
    v_max   = 11'(c.vmax);
    v_pulse = 8'(c.vp);
    v_lm    = 6'(c.vl);
    v_rm    = 4'(c.vr);
  endtask

  // One clock edge: advance the model with the load value sampled on this edge,
  // then compare every output against it.
  task automatic tick();
    @(posedge clk);
    if (load) begin
      cap    = cur;
      loaded = 1'b1;
      k      = -3;
    end else if (loaded) begin
      k++;
    end
    #1;
    chk_vec("cycle", model_vec());
  endtask

  task automatic load_cfg(input cfg_t c);
    drive(c);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_frame(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_s && n < limit);
  endtask

  initial begin
    cfg_t c640, c800, cdeg, csml, c;
    int n, pos, hs_low, vs_low, de_cnt, de_first, de_last, guard, t, pxmax, period;
    int fall1, fall2, ls_cnt;
    logic prev;
    c640 = '{799, 96, 48, 16, 524, 2, 33, 10};
    c800 = '{1055, 128, 88, 40, 5, 1, 1, 1};
    cdeg = '{99, 60, 30, 20, 3, 1, 0, 0};
    csml = '{49, 5, 5, 5, 9, 1, 1, 1};

    // Reset state, then idle until the first load
    drive(c640);
    #12;
    chk_vec("reset", reset_vec());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // First load: Frame_start exactly 3 edges after the load edge
    load_cfg(c640);
    wait_frame(10, n);
    chk("load_latency", n, 3);

    // 640x480 through line 40, h=500
    pos = 0; hs_low = (h_sync == 1'b0) ? 1 : 0; vs_low = (v_sync == 1'b0) ? 1 : 0;
    de_cnt = 0; de_first = 100000; de_last = -1; guard = 0;
    while (k != 40 * 800 + 500 && guard < 40000) begin
      tick();
      guard++;
      pos = line_s ? 0 : pos + 1;
      if (!h_sync) hs_low++;
      if (!v_sync) vs_low++;
      if (disp) begin
        de_cnt++;
        if (pos < de_first) de_first = pos;
        if (pos > de_last) de_last = pos;
      end
    end
    chk("reach_h500_v40", k, 40 * 800 + 500);
    chk("hsync_low_cycles", hs_low, 41 * 96);
    chk("vsync_low_cycles", vs_low, 2 * 800);
    chk("de_cycles", de_cnt, 5 * 640 + (500 - 144 + 1));
    chk("de_first_h", de_first, 144);
    chk("de_last_h", de_last, 783);

    // Asynchronous reset mid-frame
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("async_reset", reset_vec());
    loaded = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();

    // Mid-frame switch to 800x600 timing
    load_cfg(c640);
    wait_frame(10, n);
    chk("reload_latency", n, 3);
    repeat (1000) tick();
    load_cfg(c800);
    wait_frame(10, n);
    chk("switch_latency", n, 3);
    t = 0; pxmax = 0; period = 0;
    while (t < 4 * 1056) begin
      tick();
      t++;
      if (disp && int'(px) > pxmax) pxmax = int'(px);
      if (line_s && period == 0) period = t;
    end
    chk("line_period_800", period, 1056);
    chk("pixel_x_max_800", pxmax, 799);

    // Degenerate horizontal bounds: syncs keep running, no display enable
    load_cfg(cdeg);
    wait_frame(10, n);
    chk("degen_latency", n, 3);
    de_cnt = 0; fall1 = -1; fall2 = -1;
    for (int i = 1; i <= 400; i++) begin
      prev = h_sync;
      tick();
      if (disp) de_cnt++;
      if (prev && !h_sync) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0) fall2 = i;
      end
    end
    chk("degen_de_cycles", de_cnt, 0);
    chk("degen_hsync_period", fall2 - fall1, 100);

    // Load held 5 cycles, first held edge coinciding with an h wrap
    load_cfg(csml);
    wait_frame(10, n);
    guard = 0;
    while (k % 50 != 48 && guard < 200) begin
      tick();
      guard++;
    end
    chk("pre_wrap_pos", k % 50, 48);
    ls_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      c = csml;
      c.hmax = 40 + i;
      drive(c);
      load = 1'b1;
      tick();
      if (line_s) ls_cnt++;
    end
    load = 1'b0;
    wait_frame(10, n);
    chk("hold_no_wrap", ls_cnt, 0);
    chk("hold_latency", n, 3);

    // Randomized configurations: frame period from the captured totals
    for (int r = 0; r < 6; r++) begin
      c.hmax = int'($urandom_range(10, 60));
      c.hp   = int'($urandom_range(0, 15));
      c.hl   = int'($urandom_range(0, 15));
      c.hr   = int'($urandom_range(0, 15));
      c.vmax = int'($urandom_range(3, 12));
      c.vp   = int'($urandom_range(0, 3));
      c.vl   = int'($urandom_range(0, 3));
      c.vr   = int'($urandom_range(0, 3));
      load_cfg(c);
      wait_frame(10, n);
      chk("rand_latency", n, 3);
      t = 0;
      do begin
        tick();
        t++;
      end while (!frame_s && t < 2000);
      chk("rand_frame_period", t, (c.hmax + 1) * (c.vmax + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
